// File: rtl/token_queue_if.sv
// ---------------------------------------------------------------------------
// token_queue_if : producer/consumer handshake, flush and status bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface token_queue_if #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 133,
  parameter int TAG_W = 4,
  parameter int CNT_W = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH-1:0]           in_data;
  logic [TAG_W-1:0]           in_tag;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH-1:0]           out_data;
  logic [TAG_W-1:0]           out_tag;
  logic                       flush;
  logic [TAG_W-1:0]           flush_tag;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic [CNT_W-1:0]           squash_cnt;

  modport master (
    output in_valid, in_data, in_tag, out_ready, flush, flush_tag,
    input  in_ready, out_valid, out_data, out_tag, count, squash_cnt
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready, flush, flush_tag,
    output in_ready, out_valid, out_data, out_tag, count, squash_cnt
  );
endinterface

`default_nettype wire

// File: rtl/token_queue.sv
// ---------------------------------------------------------------------------
// token_queue : elastic circular token buffer with tag-based squash/drain
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module token_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 133,
  parameter int TAG_W = 4,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  token_queue_if.slave  bus
);
  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_occ_w = $clog2(DEPTH + 1);
  localparam int c_kn_w  = $clog2(DEPTH + 2);
  localparam int c_sum_w = CNT_W + c_kn_w;

  logic [WIDTH-1:0]   r_data [DEPTH];
  logic [TAG_W-1:0]   r_tag  [DEPTH];
  logic [DEPTH-1:0]   r_kill;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_occ_w-1:0] r_count;
  logic [CNT_W-1:0]   r_squash;

  logic               w_in_ready;
  logic               w_head_occ;
  logic               w_head_kill;
  logic               w_out_valid;
  logic               w_pop;
  logic               w_drain;
  logic               w_leave;
  logic               w_push;
  logic               w_push_kill;
  logic [DEPTH-1:0]   w_new_kill;
  logic [c_kn_w-1:0]  w_kill_num;
  logic [c_sum_w-1:0] w_sum;
  logic [CNT_W-1:0]   w_squash_nxt;
  int                 w_off;
  logic               w_occ;

  function automatic logic [c_ptr_w-1:0] f_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_in_ready  = (r_count < c_occ_w'(DEPTH));
  assign w_head_occ  = (r_count != '0);
  assign w_head_kill = r_kill[r_rd_ptr];
  assign w_out_valid = w_head_occ && !w_head_kill;
  assign w_pop       = w_out_valid && bus.out_ready;
  assign w_drain     = w_head_occ && w_head_kill;
  assign w_leave     = w_pop || w_drain;
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_push_kill = bus.flush && (bus.in_tag != bus.flush_tag);

  // The head slot leaving this cycle is exempt: it is delivered or discarded now.
  always_comb begin
    w_new_kill = '0;
    w_kill_num = '0;
    w_off      = 0;
    w_occ      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i >= int'(r_rd_ptr)) w_off = i - int'(r_rd_ptr);
      else                     w_off = i + DEPTH - int'(r_rd_ptr);
      w_occ = (w_off < int'(r_count));
      if (bus.flush && w_occ && !r_kill[i] && (r_tag[i] != bus.flush_tag)
          && !((w_off == 0) && w_leave))
        w_new_kill[i] = 1'b1;
      w_kill_num = w_kill_num + c_kn_w'(w_new_kill[i]);
    end
    w_kill_num = w_kill_num + c_kn_w'(w_push && w_push_kill);
  end

  assign w_sum        = c_sum_w'(r_squash) + c_sum_w'(w_kill_num);
  assign w_squash_nxt = (w_sum[c_sum_w-1:CNT_W] != '0) ? '1 : w_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= '0;
      end
      r_kill   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_squash <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_new_kill[i]) r_kill[i] <= 1'b1;
      end
      // The write slot is never occupied, so it cannot collide with a new kill.
      if (w_push) begin
        r_data[r_wr_ptr] <= bus.in_data;
        r_tag[r_wr_ptr]  <= bus.in_tag;
        r_kill[r_wr_ptr] <= w_push_kill;
        r_wr_ptr         <= f_inc(r_wr_ptr);
      end
      if (w_leave) r_rd_ptr <= f_inc(r_rd_ptr);
      case ({w_push, w_leave})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_squash <= w_squash_nxt;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = r_data[r_rd_ptr];
  assign bus.out_tag    = r_tag[r_rd_ptr];
  assign bus.count      = r_count;
  assign bus.squash_cnt = r_squash;

endmodule

`default_nettype wire

// File: tb/tb_token_queue.sv
// ---------------------------------------------------------------------------
// tb_token_queue : scenario tasks with a delivered-token scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_token_queue;
  logic clk = 1'b0;
  logic reset4;
  logic reset3;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  token_queue_if #(.DEPTH(4), .WIDTH(133), .TAG_W(4), .CNT_W(8)) bus4 ();
  token_queue_if #(.DEPTH(3), .WIDTH(8),   .TAG_W(4), .CNT_W(2)) bus3 ();

  token_queue #(.DEPTH(4), .WIDTH(133), .TAG_W(4), .CNT_W(8)) dut4 (
    .clk(clk), .reset(reset4), .bus(bus4));
  token_queue #(.DEPTH(3), .WIDTH(8), .TAG_W(4), .CNT_W(2)) dut3 (
    .clk(clk), .reset(reset3), .bus(bus3));

  typedef struct packed {
    logic [3:0]   tag;
    logic [132:0] data;
  } tok_t;

  tok_t exp4[$];
  tok_t got4[$];
  tok_t exp3[$];
  tok_t got3[$];
  int   got4_rd = 0;

  // Record every token actually handed to the consumer.
  always @(negedge clk) begin
    if (reset4 && bus4.out_valid && bus4.out_ready)
      got4.push_back('{tag: bus4.out_tag, data: bus4.out_data});
    if (reset3 && bus3.out_valid && bus3.out_ready)
      got3.push_back('{tag: bus3.out_tag, data: 133'(bus3.out_data)});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input logic [132:0] d, input logic [3:0] t);
    bus4.in_valid = 1'b1;
    bus4.in_data  = d;
    bus4.in_tag   = t;
    tick();
    bus4.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    tests_run += 6;
    if (bus4.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0b want 0", bus4.out_valid); end
    if (bus4.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %0b want 1", bus4.in_ready); end
    if (bus4.count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", bus4.count); end
    if (bus4.squash_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_squash: got %0d want 0", bus4.squash_cnt); end
    if (bus4.out_data !== 133'd0) begin tests_failed++; $display("FAIL reset_out_data: got %h want 0", bus4.out_data); end
    if (bus4.out_tag !== 4'd0) begin tests_failed++; $display("FAIL reset_out_tag: got %0d want 0", bus4.out_tag); end
    @(negedge clk);
    reset4 = 1'b1;
    reset3 = 1'b1;
    tick();
  endtask

  task automatic test_push();
    bus4.out_ready = 1'b0;
    bus4.in_valid  = 1'b1;
    bus4.in_data   = 133'hA;
    bus4.in_tag    = 4'd1;
    #1;
    tests_run++;
    if (bus4.out_valid !== 1'b0) begin tests_failed++; $display("FAIL push_no_bypass: got %0b want 0", bus4.out_valid); end
    tick();
    tests_run += 2;
    if (bus4.out_valid !== 1'b1) begin tests_failed++; $display("FAIL push_head_valid: got %0b want 1", bus4.out_valid); end
    if (bus4.out_data !== 133'hA) begin tests_failed++; $display("FAIL push_head_data: got %h want a", bus4.out_data); end
    exp4.push_back('{tag: 4'd1, data: 133'hA});
    push4(133'hB, 4'd2); exp4.push_back('{tag: 4'd2, data: 133'hB});
    push4(133'hC, 4'd3); exp4.push_back('{tag: 4'd3, data: 133'hC});
    tests_run += 3;
    if (bus4.count !== 3'd3) begin tests_failed++; $display("FAIL push_count: got %0d want 3", bus4.count); end
    if (bus4.out_data !== 133'hA) begin tests_failed++; $display("FAIL push_head_hold: got %h want a", bus4.out_data); end
    if (bus4.out_tag !== 4'd1) begin tests_failed++; $display("FAIL push_head_tag: got %0d want 1", bus4.out_tag); end
  endtask

  task automatic test_fill();
    tok_t e;
    push4(133'hD, 4'd3); exp4.push_back('{tag: 4'd3, data: 133'hD});
    bus4.in_valid = 1'b1;
    bus4.in_data  = 133'hE;
    bus4.in_tag   = 4'd3;
    tests_run += 2;
    if (bus4.in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_in_ready: got %0b want 0", bus4.in_ready); end
    if (bus4.count !== 3'd4) begin tests_failed++; $display("FAIL full_count: got %0d want 4", bus4.count); end
    tick();
    tests_run++;
    if (bus4.count !== 3'd4) begin tests_failed++; $display("FAIL full_hold_count: got %0d want 4", bus4.count); end
    bus4.out_ready = 1'b1;
    tick();
    bus4.out_ready = 1'b0;
    bus4.in_valid  = 1'b0;
    tests_run += 2;
    if (bus4.count !== 3'd3) begin tests_failed++; $display("FAIL full_pop_count: got %0d want 3", bus4.count); end
    if (bus4.in_ready !== 1'b1) begin tests_failed++; $display("FAIL full_pop_ready: got %0b want 1", bus4.in_ready); end
    bus4.out_ready = 1'b1;
    repeat (3) tick();
    bus4.out_ready = 1'b0;
    tests_run++;
    if (bus4.count !== 3'd0) begin tests_failed++; $display("FAIL fill_drain_count: got %0d want 0", bus4.count); end
    while (exp4.size() > 0) begin
      e = exp4.pop_front();
      tests_run++;
      if (got4_rd >= got4.size()) begin tests_failed++; $display("FAIL fill_sb: got none want %h/%0d", e.data, e.tag); end
      else if (got4[got4_rd] !== e) begin tests_failed++; $display("FAIL fill_sb: got %h/%0d want %h/%0d", got4[got4_rd].data, got4[got4_rd].tag, e.data, e.tag); end
      got4_rd++;
    end
  endtask

  task automatic test_squash();
    tok_t e;
    push4(133'h11, 4'd1);
    push4(133'h12, 4'd1);
    push4(133'h21, 4'd2); exp4.push_back('{tag: 4'd2, data: 133'h21});
    push4(133'h22, 4'd2); exp4.push_back('{tag: 4'd2, data: 133'h22});
    bus4.flush     = 1'b1;
    bus4.flush_tag = 4'd2;
    tick();
    bus4.flush = 1'b0;
    tests_run += 3;
    if (bus4.squash_cnt !== 8'd2) begin tests_failed++; $display("FAIL squash_cnt: got %0d want 2", bus4.squash_cnt); end
    if (bus4.out_valid !== 1'b0) begin tests_failed++; $display("FAIL squash_valid0: got %0b want 0", bus4.out_valid); end
    if (bus4.count !== 3'd4) begin tests_failed++; $display("FAIL squash_count4: got %0d want 4", bus4.count); end
    tick();
    tests_run += 2;
    if (bus4.out_valid !== 1'b0) begin tests_failed++; $display("FAIL squash_valid1: got %0b want 0", bus4.out_valid); end
    if (bus4.count !== 3'd3) begin tests_failed++; $display("FAIL squash_count3: got %0d want 3", bus4.count); end
    tick();
    tests_run += 4;
    if (bus4.count !== 3'd2) begin tests_failed++; $display("FAIL squash_count2: got %0d want 2", bus4.count); end
    if (bus4.out_valid !== 1'b1) begin tests_failed++; $display("FAIL squash_live_valid: got %0b want 1", bus4.out_valid); end
    if (bus4.out_tag !== 4'd2) begin tests_failed++; $display("FAIL squash_live_tag: got %0d want 2", bus4.out_tag); end
    if (bus4.out_data !== 133'h21) begin tests_failed++; $display("FAIL squash_live_data: got %h want 21", bus4.out_data); end
    bus4.out_ready = 1'b1;
    repeat (2) tick();
    bus4.out_ready = 1'b0;
    while (exp4.size() > 0) begin
      e = exp4.pop_front();
      tests_run++;
      if (got4_rd >= got4.size()) begin tests_failed++; $display("FAIL squash_sb: got none want %h/%0d", e.data, e.tag); end
      else if (got4[got4_rd] !== e) begin tests_failed++; $display("FAIL squash_sb: got %h/%0d want %h/%0d", got4[got4_rd].data, got4[got4_rd].tag, e.data, e.tag); end
      got4_rd++;
    end
  endtask

  task automatic test_flush_pop();
    tok_t e;
    push4(133'h31, 4'd3); exp4.push_back('{tag: 4'd3, data: 133'h31});
    push4(133'h32, 4'd3);
    push4(133'h33, 4'd3);
    bus4.out_ready = 1'b1;
    bus4.flush     = 1'b1;
    bus4.flush_tag = 4'd5;
    bus4.in_valid  = 1'b1;
    bus4.in_data   = 133'h34;
    bus4.in_tag    = 4'd3;
    tick();
    bus4.out_ready = 1'b0;
    bus4.in_valid  = 1'b0;
    tests_run += 3;
    if (bus4.squash_cnt !== 8'd5) begin tests_failed++; $display("FAIL flushpop_squash: got %0d want 5", bus4.squash_cnt); end
    if (bus4.count !== 3'd3) begin tests_failed++; $display("FAIL flushpop_count: got %0d want 3", bus4.count); end
    if (bus4.out_valid !== 1'b0) begin tests_failed++; $display("FAIL flushpop_valid: got %0b want 0", bus4.out_valid); end
    tick();
    bus4.flush = 1'b0;
    tests_run += 2;
    if (bus4.squash_cnt !== 8'd5) begin tests_failed++; $display("FAIL reflush_squash: got %0d want 5", bus4.squash_cnt); end
    if (bus4.count !== 3'd2) begin tests_failed++; $display("FAIL reflush_count: got %0d want 2", bus4.count); end
    repeat (2) tick();
    tests_run++;
    if (bus4.count !== 3'd0) begin tests_failed++; $display("FAIL flushpop_drained: got %0d want 0", bus4.count); end
    while (exp4.size() > 0) begin
      e = exp4.pop_front();
      tests_run++;
      if (got4_rd >= got4.size()) begin tests_failed++; $display("FAIL flushpop_sb: got none want %h/%0d", e.data, e.tag); end
      else if (got4[got4_rd] !== e) begin tests_failed++; $display("FAIL flushpop_sb: got %h/%0d want %h/%0d", got4[got4_rd].data, got4[got4_rd].tag, e.data, e.tag); end
      got4_rd++;
    end
    tests_run++;
    if (got4.size() != got4_rd) begin tests_failed++; $display("FAIL extra_tokens: got %0d want %0d", got4.size(), got4_rd); end
  endtask

  task automatic test_wrap();
    tok_t e;
    int   nxt = 0;
    int   cyc = 0;
    int   idx = 0;
    logic acc;
    while (got3.size() < 10 && cyc < 200) begin
      bus3.in_valid  = (nxt < 10);
      bus3.in_data   = 8'(nxt);
      bus3.in_tag    = 4'd0;
      bus3.out_ready = 1'($urandom_range(0, 1));
      #1;
      acc = bus3.in_valid && bus3.in_ready;
      if (acc) exp3.push_back('{tag: 4'd0, data: 133'(nxt)});
      tick();
      if (acc) nxt++;
      cyc++;
    end
    bus3.in_valid  = 1'b0;
    bus3.out_ready = 1'b0;
    tests_run++;
    if (cyc >= 200) begin tests_failed++; $display("FAIL wrap_timeout: got %0d tokens want 10", got3.size()); end
    while (exp3.size() > 0) begin
      e = exp3.pop_front();
      tests_run++;
      if (idx >= got3.size()) begin tests_failed++; $display("FAIL wrap_sb: got none want %0d", e.data); end
      else if (got3[idx] !== e) begin tests_failed++; $display("FAIL wrap_sb: got %0d want %0d", got3[idx].data, e.data); end
      idx++;
    end
    tests_run++;
    if (idx != 10) begin tests_failed++; $display("FAIL wrap_total: got %0d want 10", idx); end
  endtask

  task automatic test_saturate();
    bus3.flush     = 1'b1;
    bus3.flush_tag = 4'd1;
    tick();
    bus3.flush = 1'b0;
    tests_run += 2;
    if (bus3.squash_cnt !== 2'd0) begin tests_failed++; $display("FAIL empty_flush_squash: got %0d want 0", bus3.squash_cnt); end
    if (bus3.count !== 2'd0) begin tests_failed++; $display("FAIL empty_flush_count: got %0d want 0", bus3.count); end
    bus3.in_valid = 1'b1;
    bus3.in_tag   = 4'd0;
    repeat (3) tick();
    bus3.in_valid = 1'b0;
    tests_run++;
    if (bus3.in_ready !== 1'b0) begin tests_failed++; $display("FAIL d3_full_ready: got %0b want 0", bus3.in_ready); end
    bus3.flush = 1'b1;
    tick();
    bus3.flush = 1'b0;
    tests_run++;
    if (bus3.squash_cnt !== 2'd3) begin tests_failed++; $display("FAIL d3_squash3: got %0d want 3", bus3.squash_cnt); end
    repeat (3) tick();
    bus3.in_valid = 1'b1;
    bus3.flush    = 1'b1;
    tick();
    bus3.in_valid = 1'b0;
    bus3.flush    = 1'b0;
    tests_run += 3;
    if (bus3.squash_cnt !== 2'd3) begin tests_failed++; $display("FAIL squash_saturate: got %0d want 3", bus3.squash_cnt); end
    if (bus3.count !== 2'd1) begin tests_failed++; $display("FAIL killed_push_count: got %0d want 1", bus3.count); end
    if (bus3.out_valid !== 1'b0) begin tests_failed++; $display("FAIL killed_push_valid: got %0b want 0", bus3.out_valid); end
    tick();
    tests_run++;
    if (bus3.count !== 2'd0) begin tests_failed++; $display("FAIL killed_push_drain: got %0d want 0", bus3.count); end
  endtask

  task automatic test_async_reset();
    push4(133'h41, 4'd1);
    push4(133'h42, 4'd1);
    push4(133'h43, 4'd2);
    bus4.flush     = 1'b1;
    bus4.flush_tag = 4'd2;
    tick();
    bus4.flush = 1'b0;
    tests_run += 2;
    if (bus4.count !== 3'd3) begin tests_failed++; $display("FAIL prereset_count: got %0d want 3", bus4.count); end
    if (bus4.squash_cnt !== 8'd7) begin tests_failed++; $display("FAIL prereset_squash: got %0d want 7", bus4.squash_cnt); end
    #2;
    reset4 = 1'b0;
    #1;
    tests_run += 4;
    if (bus4.out_valid !== 1'b0) begin tests_failed++; $display("FAIL areset_valid: got %0b want 0", bus4.out_valid); end
    if (bus4.count !== 3'd0) begin tests_failed++; $display("FAIL areset_count: got %0d want 0", bus4.count); end
    if (bus4.squash_cnt !== 8'd0) begin tests_failed++; $display("FAIL areset_squash: got %0d want 0", bus4.squash_cnt); end
    if (bus4.in_ready !== 1'b1) begin tests_failed++; $display("FAIL areset_ready: got %0b want 1", bus4.in_ready); end
    @(negedge clk);
    reset4 = 1'b1;
    tick();
    tests_run++;
    if (bus4.count !== 3'd0) begin tests_failed++; $display("FAIL postreset_count: got %0d want 0", bus4.count); end
  endtask

  initial begin
    reset4 = 1'b0;
    reset3 = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_tag = '0;
    bus4.out_ready = 1'b0; bus4.flush = 1'b0; bus4.flush_tag = '0;
    bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.in_tag = '0;
    bus3.out_ready = 1'b0; bus3.flush = 1'b0; bus3.flush_tag = '0;
    test_reset();
    test_push();
    test_fill();
    test_squash();
    test_flush_pop();
    test_wrap();
    test_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

`default_nettype wire
